// File: rtl/mem_responder.sv
// Word-array memory responder: accepts one request in S_Idle, inserts WaitStates wait cycles, then pulses Ready.
// Define MEM_ALIGN_CHECK_EN to flag odd byte addresses as misaligned (no access, Err with Ready).
module mem_responder #(
  parameter int DataWidth  = 16,
  parameter int AddrWidth  = 8,
  parameter int WaitStates = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 MEM_En,
  input  logic                 MEM_Wr,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Err
);

  localparam int WordBits = AddrWidth - 1;
  localparam int Depth    = 1 << WordBits;
  localparam logic [3:0] WaitLoad = 4'(WaitStates);
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic AlignCheck = 1'b1;
`else
  localparam logic AlignCheck = 1'b0;
`endif

  typedef enum logic [1:0] {S_Idle, S_Wait, S_Access, S_Done} state_t;

  state_t               state, next_state;
  logic [3:0]           wait_cnt;
  logic [WordBits-1:0]  word_q;
  logic                 wr_q;
  logic                 misaligned_q;
  logic [DataWidth-1:0] din_q;
  logic [DataWidth-1:0] mem [Depth];
  logic                 accept;
  logic                 do_access;

  assign accept    = (state == S_Idle) && MEM_En;
  assign do_access = (state == S_Access) && !misaligned_q;

  always_comb begin
    next_state = state;
    case (state)
      S_Idle:   if (MEM_En) next_state = (WaitLoad == 4'd0) ? S_Access : S_Wait;
      S_Wait:   if (wait_cnt <= 4'd1) next_state = S_Access;
      S_Access: next_state = S_Done;
      S_Done:   next_state = S_Idle;
      default:  next_state = S_Idle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_Idle;
    else       state <= next_state;
  end

  // Request fields are captured only at acceptance, so bus changes while busy never leak in.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt     <= 4'd0;
      word_q       <= '0;
      wr_q         <= 1'b0;
      misaligned_q <= 1'b0;
      din_q        <= '0;
      DOut         <= '0;
    end else begin
      if (accept) begin
        wait_cnt     <= WaitLoad;
        word_q       <= Addr[AddrWidth-1:1];
        wr_q         <= MEM_Wr;
        misaligned_q <= Addr[0] & AlignCheck;
        din_q        <= DIn;
      end else if (state == S_Wait) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access && !wr_q) DOut <= mem[word_q];
    end
  end

  // Array has no reset; a reset before S_Access is clocked leaves do_access low, dropping the write.
  always_ff @(posedge Clk) begin
    if (do_access && wr_q) mem[word_q] <= din_q;
  end

  assign Ready = (state == S_Done);
  assign Busy  = (state != S_Idle);
`ifdef MEM_ALIGN_CHECK_EN
  assign Err = Ready & misaligned_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WaitStates 0, 1 and 3.
// Expectations follow MEM_ALIGN_CHECK_EN when the bench is built with it defined.
module tb_mem_responder;

  logic        Clock_TB;
  logic        reset_v [3];
  logic        mem_en  [3];
  logic        mem_wr  [3];
  logic [7:0]  addr    [3];
  logic [15:0] din     [3];
  logic [15:0] dout    [3];
  logic        ready   [3];
  logic        busy    [3];
  logic        err     [3];

  int checks = 0;
  int errors = 0;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  mem_responder #(.DataWidth(16), .AddrWidth(8), .WaitStates(0)) u_w0 (
    .Clk(Clock_TB), .Reset(reset_v[0]), .MEM_En(mem_en[0]), .MEM_Wr(mem_wr[0]),
    .Addr(addr[0]), .DIn(din[0]), .DOut(dout[0]), .Ready(ready[0]), .Busy(busy[0]), .Err(err[0]));

  mem_responder #(.DataWidth(16), .AddrWidth(8), .WaitStates(1)) u_w1 (
    .Clk(Clock_TB), .Reset(reset_v[1]), .MEM_En(mem_en[1]), .MEM_Wr(mem_wr[1]),
    .Addr(addr[1]), .DIn(din[1]), .DOut(dout[1]), .Ready(ready[1]), .Busy(busy[1]), .Err(err[1]));

  mem_responder #(.DataWidth(16), .AddrWidth(8), .WaitStates(3)) u_w3 (
    .Clk(Clock_TB), .Reset(reset_v[2]), .MEM_En(mem_en[2]), .MEM_Wr(mem_wr[2]),
    .Addr(addr[2]), .DIn(din[2]), .DOut(dout[2]), .Ready(ready[2]), .Busy(busy[2]), .Err(err[2]));

  initial Clock_TB = 1'b0;
  always #5 Clock_TB = ~Clock_TB;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wait_of(input int idx);
    case (idx)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request; bus inputs are scrambled right after acceptance to prove they are ignored.
  task automatic applyStimulus(input int idx, input logic wr, input logic [7:0] a, input logic [15:0] d,
                               input logic [15:0] exp_dout, input logic exp_err, input string tag);
    int lat;
    @(negedge Clock_TB);
    mem_en[idx] = 1'b1;
    mem_wr[idx] = wr;
    addr[idx]   = a;
    din[idx]    = d;
    @(posedge Clock_TB); #1;
    checkOutput({tag, ":busy_rise"}, busy[idx], 1);
    mem_en[idx] = 1'b0;
    mem_wr[idx] = ~wr;
    addr[idx]   = a ^ 8'h02;
    din[idx]    = ~d;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clock_TB); #1;
      if (ready[idx]) begin
        lat = i;
        break;
      end
    end
    checkOutput({tag, ":ready_latency"}, lat, wait_of(idx) + 1);
    checkOutput({tag, ":dout"}, dout[idx], exp_dout);
    checkOutput({tag, ":err"}, err[idx], exp_err);
    @(posedge Clock_TB); #1;
    checkOutput({tag, ":ready_pulse_end"}, ready[idx], 0);
    checkOutput({tag, ":busy_fall"}, busy[idx], 0);
  endtask

  initial begin
    int ready_seen;
    for (int k = 0; k < 3; k++) begin
      reset_v[k] = 1'b1;
      mem_en[k]  = 1'b0;
      mem_wr[k]  = 1'b0;
      addr[k]    = 8'h00;
      din[k]     = 16'h0000;
    end
    repeat (2) @(posedge Clock_TB);
    @(negedge Clock_TB);
    for (int k = 0; k < 3; k++) reset_v[k] = 1'b0;
    @(negedge Clock_TB);
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset:dout", dout[k], 16'h0000);
      checkOutput("reset:ready", ready[k], 0);
      checkOutput("reset:busy", busy[k], 0);
      checkOutput("reset:err", err[k], 0);
    end

    // W=1 write then read, DOut must hold afterwards
    applyStimulus(1, 1'b1, 8'h04, 16'h9101, 16'h0000, 1'b0, "w1_write04");
    applyStimulus(1, 1'b0, 8'h04, 16'h0000, 16'h9101, 1'b0, "w1_read04");
    repeat (3) @(negedge Clock_TB);
    checkOutput("w1_dout_hold", dout[1], 16'h9101);

    // Misalignment on W=1
    applyStimulus(1, 1'b1, 8'h04, 16'h4444, 16'h9101, 1'b0, "mis_prewrite04");
    applyStimulus(1, 1'b1, 8'h05, 16'hBEEF, 16'h9101, AlignOn, "mis_write05");
    applyStimulus(1, 1'b0, 8'h04, 16'h0000, AlignOn ? 16'h4444 : 16'hBEEF, 1'b0, "mis_read04");
    applyStimulus(1, 1'b0, 8'h05, 16'h0000, AlignOn ? 16'h4444 : 16'hBEEF, AlignOn, "mis_read05");

    // Wrap-around on W=1
    applyStimulus(1, 1'b1, 8'h00, 16'h0F0F, AlignOn ? 16'h4444 : 16'hBEEF, 1'b0, "wrap_write00");
    applyStimulus(1, 1'b1, 8'hFE, 16'h5A5A, AlignOn ? 16'h4444 : 16'hBEEF, 1'b0, "wrap_writeFE");
    applyStimulus(1, 1'b0, 8'hFE, 16'h0000, 16'h5A5A, 1'b0, "wrap_readFE");
    applyStimulus(1, 1'b0, 8'h00, 16'h0000, 16'h0F0F, 1'b0, "wrap_read00");

    // W=0 preload, then back-to-back reads with MEM_En held high
    applyStimulus(0, 1'b1, 8'h00, 16'h1111, 16'h0000, 1'b0, "w0_write00");
    applyStimulus(0, 1'b1, 8'h02, 16'h2222, 16'h0000, 1'b0, "w0_write02");
    @(negedge Clock_TB);
    mem_en[0] = 1'b1;
    mem_wr[0] = 1'b0;
    addr[0]   = 8'h00;
    din[0]    = 16'h0000;
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:busy_e0", busy[0], 1);
    addr[0] = 8'h02;
    din[0]  = 16'hDEAD;
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:ready_e1", ready[0], 1);
    checkOutput("w0_hold:dout_first", dout[0], 16'h1111);
    mem_wr[0] = 1'b1;
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:ready_e2", ready[0], 0);
    checkOutput("w0_hold:busy_e2", busy[0], 0);
    mem_wr[0] = 1'b0;
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:ready_e3", ready[0], 0);
    checkOutput("w0_hold:busy_e3", busy[0], 1);
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:ready_e4", ready[0], 1);
    checkOutput("w0_hold:dout_second", dout[0], 16'h2222);
    mem_en[0] = 1'b0;
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:ready_e5", ready[0], 0);
    @(posedge Clock_TB); #1;
    checkOutput("w0_hold:busy_e6", busy[0], 0);

    // W=3 reset during the second wait cycle of a write
    applyStimulus(2, 1'b1, 8'h10, 16'h1234, 16'h0000, 1'b0, "w3_prewrite10");
    @(negedge Clock_TB);
    mem_en[2] = 1'b1;
    mem_wr[2] = 1'b1;
    addr[2]   = 8'h10;
    din[2]    = 16'hAAAA;
    @(posedge Clock_TB); #1;
    mem_en[2] = 1'b0;
    checkOutput("w3_rst:busy_e0", busy[2], 1);
    @(posedge Clock_TB); #1;
    checkOutput("w3_rst:busy_wait2", busy[2], 1);
    reset_v[2] = 1'b1;
    #1;
    checkOutput("w3_rst:busy_async", busy[2], 0);
    checkOutput("w3_rst:ready_async", ready[2], 0);
    @(negedge Clock_TB);
    reset_v[2] = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock_TB);
      if (ready[2]) ready_seen++;
    end
    checkOutput("w3_rst:no_ready", ready_seen, 0);
    checkOutput("w3_rst:dout_cleared", dout[2], 16'h0000);
    applyStimulus(2, 1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0, "w3_read10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
